example_sweep_ctrl: RTL and testbench
=====================================

// Module: example_sweep_ctrl
// PURPOSE
//  Sequencer for the 6-input combinational evaluator (module example, inputs A..F, output Y).
//  On start, drives all 2^N_IN input vectors in ascending order.
//  Waits SETTLE_CYC cycles per vector, samples Y and assembles the full truth table.
//  Used for self-characterisation of the evaluator in-system. It replaces hand-written vector lists.
// PARAMETERS
//  N_IN        6   evaluator input count; NVEC = 2**N_IN vectors
//  SETTLE_CYC  2   cycles vec_o is held before y_i is sampled; legal range >= 1
// PORTS
//  clk          in   1         single clock; all state updates on rising edge
//  rst          in   1         synchronous, active-high reset
//  start_i      in   1         request a sweep; accepted only in IDLE
//  abort_i      in   1         cancel the sweep in progress
//  vec_o        out  N_IN      evaluator inputs: vec_o[5]=A, [4]=B, [3]=C, [2]=D, [1]=E, [0]=F
//  y_i          in   1         evaluator output Y
//  busy_o       out  1         high in SETTLE and SAMPLE
//  done_o       out  1         one-cycle pulse; high only in the DONE state
//  tt_o         out  NVEC      truth table; bit i = Y sampled with vec_o == i
//  tt_valid_o   out  1         tt_o holds a complete sweep
// BEHAVIOUR
//  Reset (rst=1 at an edge, in any state): state=IDLE, vec_o=0, tt_o=0, tt_valid_o=0, busy_o=0, done_o=0.
//   Reset mid-sweep discards the partial table.
//  FSM states: IDLE, SETTLE, SAMPLE, DONE.
//  IDLE:
//   - start_i & !abort_i -> SETTLE; vec_o<=0; cnt<=0; tt_valid_o<=0.
//   - If start_i and abort_i are both high, abort wins and the FSM stays in IDLE.
//  SETTLE:
//   - cnt==SETTLE_CYC-1 -> SAMPLE; otherwise cnt++.
//  SAMPLE:
//   - tt_o[vec_o]<=y_i.
//   - If vec_o==NVEC-1 -> DONE. Otherwise vec_o++, cnt<=0, -> SETTLE.
//  DONE (one cycle):
//   - done_o=1; tt_valid_o<=1; vec_o<=0; -> IDLE.
//  vec_o never wraps within a sweep. It is held at NVEC-1 through DONE.
//  Per-vector cost is SETTLE_CYC+1 cycles.
//  Latency: the start_i accept edge is cycle 0; done_o is high in cycle NVEC*(SETTLE_CYC+1)+1.
//   With default parameters this is cycle 193.
//  start_i in SETTLE, SAMPLE or DONE is ignored. It is not queued.
//  abort_i in SETTLE or SAMPLE:
//   - -> IDLE at the next edge; vec_o<=0; no done_o pulse; tt_valid_o stays 0.
//   - tt_o keeps its partial contents.
//  abort_i in DONE or IDLE has no effect.
//  tt_o bits not yet written in the current sweep retain their previous values.
// CONFIGURATION
//  Macro MISMATCH_CHECK_EN, when defined, adds the following ports:
//   expect_i      in   NVEC    golden truth table; must be stable for the whole sweep
//   mismatch_o    out  1       sticky flag; set in SAMPLE when y_i != expect_i[vec_o]
//   first_fail_o  out  N_IN    vec_o of the first mismatch; later mismatches do not update it
//   Both outputs are cleared on reset and on start acceptance.
//   Both are valid when done_o is high and are held until the next start.
//  When MISMATCH_CHECK_EN is undefined: these ports and their logic are absent; all other behaviour is identical.
// STRUCTURE
//  Package example_sweep_pkg:
//   - state enum {IDLE, SETTLE, SAMPLE, DONE}
//   - default N_IN and the NVEC localparam
//   - PARITY6_TT = 64'h6996966996696996 (bench constant)
//  Sub-module sweep_settle_timer: counter with load, count-enable and terminal-count (tc) output, sized $clog2(SETTLE_CYC+1).
//   The FSM, vector counter and truth-table register stay in the top level.
// TESTING (bench models the evaluator with a combinational function of vec_o)
//  1. rst, then y_i=^vec_o, start_i pulse:
//     -> busy_o=1 from cycle 1; done_o in cycle 193; tt_o=64'h6996966996696996; tt_valid_o=1.
//  2. y_i=vec_o[5] (Y=A):
//     -> tt_o=64'hFFFFFFFF00000000 at done_o. vec_o steps 0..63 in order, each value held 3 cycles.
//  3. abort_i while vec_o==10:
//     -> next cycle IDLE, vec_o=0, busy_o=0, no done_o, tt_valid_o=0.
//     Start_i in the same IDLE cycle as abort_i -> stays IDLE.
//  4. start_i re-pulsed at vec_o==20 mid-sweep -> ignored; done_o still in cycle 193, once.
//  5. rst for one cycle at vec_o==30 -> all outputs at their reset values after that edge; a fresh start completes normally.
//  6. With MISMATCH_CHECK_EN: expect_i=PARITY6_TT with bits 37 and 50 flipped
//     -> mismatch_o=1, first_fail_o=37 at done_o.
//     expect_i equal to the sampled table -> mismatch_o=0.

Source files
------------

// File: rtl/example_sweep_pkg.sv
// ---------------------------------------------------------------------------
// example_sweep_pkg
//   Shared types and constants for the truth-table sweep controller.
//   - state_e     : sweep FSM states
//   - DEF_N_IN    : default evaluator input count
//   - DEF_NVEC    : default number of input vectors (2**DEF_N_IN)
//   - PARITY6_TT  : truth table of 6-input XOR, a handy known-good reference
// ---------------------------------------------------------------------------
package example_sweep_pkg;

  localparam int DEF_N_IN = 6;
  localparam int DEF_NVEC = 2 ** DEF_N_IN;

  localparam logic [63:0] PARITY6_TT = 64'h6996966996696996;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/example_sweep_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// sweep_settle_timer
//   Settle-time counter for the sweep controller. load_i clears the count,
//   en_i increments it, tc_o flags the last settle cycle (count ==
//   SETTLE_CYC-1). Width is $clog2(SETTLE_CYC+1).
// Ports
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   load_i  in  clear count to zero (wins over en_i)
//   en_i    in  increment count
//   tc_o    out terminal count reached
// ---------------------------------------------------------------------------
module sweep_settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int W = $clog2(SETTLE_CYC + 1);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its inputs.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == W'(SETTLE_CYC - 1));

endmodule

// File: rtl/example_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// example_sweep_ctrl
//   Drives all 2**N_IN input vectors of a combinational evaluator in
//   ascending order, holds each for SETTLE_CYC cycles, samples y_i and
//   assembles the complete truth table in tt_o.
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start_i       request a sweep (accepted only in IDLE)
//   abort_i       cancel a sweep in progress (wins over start_i in IDLE)
//   vec_o         evaluator inputs, vec_o[5]=A ... vec_o[0]=F
//   y_i           evaluator output
//   busy_o        high while settling/sampling
//   done_o        one-cycle pulse at sweep completion
//   tt_o          truth table, bit i = Y for vec_o == i
//   tt_valid_o    tt_o holds a complete sweep
// Optional (macro MISMATCH_CHECK_EN):
//   expect_i      golden truth table, stable during the sweep
//   mismatch_o    sticky: some sample differed from expect_i
//   first_fail_o  vector of the first mismatch
// ---------------------------------------------------------------------------
module example_sweep_ctrl
  import example_sweep_pkg::*;
#(
  parameter  int N_IN       = DEF_N_IN,
  parameter  int SETTLE_CYC = 2,
  localparam int NVEC       = 2 ** N_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [N_IN-1:0]   vec_o,
  input  logic              y_i,
`ifdef MISMATCH_CHECK_EN
  input  logic [NVEC-1:0]   expect_i,
  output logic              mismatch_o,
  output logic [N_IN-1:0]   first_fail_o,
`endif
  output logic              busy_o,
  output logic              done_o,
  output logic [NVEC-1:0]   tt_o,
  output logic              tt_valid_o
);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [NVEC-1:0]   tt_q, tt_d;
  logic              tt_valid_q, tt_valid_d;
  logic              tmr_load, tmr_en, tmr_tc;

`ifdef MISMATCH_CHECK_EN
  logic              mm_q, mm_d;
  logic [N_IN-1:0]   ff_q, ff_d;
`endif

  sweep_settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_load),
    .en_i   (tmr_en),
    .tc_o   (tmr_tc)
  );

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    tt_d       = tt_q;
    tt_valid_d = tt_valid_q;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
`ifdef MISMATCH_CHECK_EN
    mm_d       = mm_q;
    ff_d       = ff_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d    = SETTLE;
          vec_d      = '0;
          tmr_load   = 1'b1;
          tt_valid_d = 1'b0;
`ifdef MISMATCH_CHECK_EN
          mm_d       = 1'b0;
          ff_d       = '0;
`endif
        end
      end

      SETTLE: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_d = IDLE;
          vec_d   = '0;
        end else if (tmr_tc) begin
          state_d = SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end

      SAMPLE: begin
        busy_o = 1'b1;
        // An abort in the sample cycle drops that sample; earlier bits stay.
        if (abort_i) begin
          state_d = IDLE;
          vec_d   = '0;
        end else begin
          tt_d[vec_q] = y_i;
`ifdef MISMATCH_CHECK_EN
          if (y_i != expect_i[vec_q]) begin
            mm_d = 1'b1;
            if (!mm_q) ff_d = vec_q;
          end
`endif
          if (vec_q == N_IN'(NVEC - 1)) begin
            state_d = DONE;
          end else begin
            vec_d    = vec_q + N_IN'(1);
            tmr_load = 1'b1;
            state_d  = SETTLE;
          end
        end
      end

      DONE: begin
        done_o     = 1'b1;
        tt_valid_d = 1'b1;
        vec_d      = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: tt_q is a flat register, not a RAM, so it takes a reset; a reset
  // mid-sweep must discard any partial table.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      tt_q       <= '0;
      tt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      tt_q       <= tt_d;
      tt_valid_q <= tt_valid_d;
    end
  end

`ifdef MISMATCH_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mm_q <= 1'b0;
      ff_q <= '0;
    end else begin
      mm_q <= mm_d;
      ff_q <= ff_d;
    end
  end

  assign mismatch_o   = mm_q;
  assign first_fail_o = ff_q;
`endif

  assign vec_o      = vec_q;
  assign tt_o       = tt_q;
  assign tt_valid_o = tt_valid_q;

endmodule

// File: tb/tb_example_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_example_sweep_ctrl
//   Bench for example_sweep_ctrl. The evaluator is modelled as a function of
//   vec_o selected by eval_mode (parity, Y=A, or a random 64-bit table).
//   model_tt tracks what tt_o must contain after each sweep/abort/reset.
// ---------------------------------------------------------------------------
module tb_example_sweep_ctrl;
  import example_sweep_pkg::*;

  localparam int N    = 6;
  localparam int NV   = 64;
  localparam int S    = 2;
  localparam int LAT  = NV * (S + 1) + 1;   // done_o cycle after accept

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [N-1:0]  vec_o;
  logic          y_i;
  logic          busy_o;
  logic          done_o;
  logic [NV-1:0] tt_o;
  logic          tt_valid_o;
`ifdef MISMATCH_CHECK_EN
  logic [NV-1:0] expect_i;
  logic          mismatch_o;
  logic [N-1:0]  first_fail_o;
  logic          last_mm;
  logic [N-1:0]  last_ff;
`endif

  int            checks = 0;
  int            errors = 0;
  int            eval_mode;
  logic [63:0]   golden;
  logic [63:0]   model_tt;

  example_sweep_ctrl #(.N_IN(N), .SETTLE_CYC(S)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .vec_o        (vec_o),
    .y_i          (y_i),
`ifdef MISMATCH_CHECK_EN
    .expect_i     (expect_i),
    .mismatch_o   (mismatch_o),
    .first_fail_o (first_fail_o),
`endif
    .busy_o       (busy_o),
    .done_o       (done_o),
    .tt_o         (tt_o),
    .tt_valid_o   (tt_valid_o)
  );

  always #5 clk = ~clk;

  // Evaluator model
  always_comb begin
    case (eval_mode)
      0:       y_i = ^vec_o;
      1:       y_i = vec_o[5];
      default: y_i = golden[vec_o];
    endcase
  end

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_tt = '0;
    checks++;
    if (vec_o !== '0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
        tt_o !== '0 || tt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset: vec=%0d busy=%b done=%b tt=%h valid=%b, want all 0",
               vec_o, busy_o, done_o, tt_o, tt_valid_o);
    end
`ifdef MISMATCH_CHECK_EN
    checks++;
    if (mismatch_o !== 1'b0 || first_fail_o !== '0) begin
      errors++;
      $display("FAIL reset_mm: mm=%b ff=%0d, want 0/0", mismatch_o, first_fail_o);
    end
`endif
  endtask

  // Full sweep from IDLE; optional start re-pulse at vector restart_at.
  task automatic run_sweep(input string name, input logic [63:0] exp_tt,
                           input int restart_at);
    int n, done_cnt, done_at, vec_bad;
    bit pulsed;
    done_cnt = 0; done_at = -1; vec_bad = 0; pulsed = 0;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    n = 1;
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL %s_busy_c1: busy=%b want 1", name, busy_o);
    end
    while (n < LAT + 20) begin
      if (done_o === 1'b1) begin
        done_cnt++;
        done_at = n;
        checks++;
        if (tt_o !== exp_tt || vec_o !== 6'd63) begin
          errors++;
          $display("FAIL %s_tt: tt=%h vec=%0d want tt=%h vec=63", name, tt_o, vec_o, exp_tt);
        end
`ifdef MISMATCH_CHECK_EN
        last_mm = mismatch_o;
        last_ff = first_fail_o;
`endif
      end
      if (busy_o === 1'b1) begin
        // Each vector is held S+1 cycles, in ascending order.
        checks++;
        if (vec_o !== N'((n - 1) / (S + 1))) begin
          errors++;
          vec_bad++;
          if (vec_bad < 4)
            $display("FAIL %s_vec: cycle %0d vec=%0d want %0d", name, n, vec_o, (n - 1) / (S + 1));
        end
      end
      start_i = 1'b0;
      if (restart_at >= 0 && !pulsed && busy_o && vec_o == N'(restart_at)) begin
        start_i = 1'b1;
        pulsed  = 1;
      end
      @(negedge clk);
      n++;
    end
    start_i = 1'b0;
    checks++;
    if (done_cnt != 1 || done_at != LAT) begin
      errors++;
      $display("FAIL %s_done: pulses=%0d at=%0d want 1 at %0d", name, done_cnt, done_at, LAT);
    end
    checks++;
    if (tt_valid_o !== 1'b1 || busy_o !== 1'b0 || vec_o !== '0 || tt_o !== exp_tt) begin
      errors++;
      $display("FAIL %s_post: valid=%b busy=%b vec=%0d tt=%h want 1/0/0/%h",
               name, tt_valid_o, busy_o, vec_o, tt_o, exp_tt);
    end
    model_tt = exp_tt;
  endtask

  // Start a sweep and return at the first negedge where vec_o == k.
  task automatic start_and_reach(input string name, input int k);
    int n;
    start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    n = 0;
    while (vec_o != N'(k) && n < LAT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (vec_o !== N'(k)) begin
      errors++;
      $display("FAIL %s_reach: vec=%0d want %0d", name, vec_o, k);
    end
  endtask

  task automatic test_abort(input string name, input int k);
    logic [63:0] mask, exp;
    int          seen_done;
    start_and_reach(name, k);
    abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || vec_o !== '0 || done_o !== 1'b0 || tt_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b vec=%0d done=%b valid=%b want 0/0/0/0",
               name, busy_o, vec_o, done_o, tt_valid_o);
    end
    // Bits below k come from this sweep, the rest are left from before.
    mask = (64'd1 << k) - 64'd1;
    exp  = (model_tt & ~mask) | (golden_of_mode() & mask);
    checks++;
    if (tt_o !== exp) begin
      errors++;
      $display("FAIL %s_partial: tt=%h want %h", name, tt_o, exp);
    end
    model_tt = exp;
    seen_done = 0;
    repeat (10) begin
      if (done_o || busy_o) seen_done++;
      @(negedge clk);
    end
    checks++;
    if (seen_done != 0) begin
      errors++;
      $display("FAIL %s_quiet: active cycles=%0d want 0", name, seen_done);
    end
  endtask

  function automatic logic [63:0] golden_of_mode();
    logic [63:0] t;
    for (int i = 0; i < 64; i++) begin
      case (eval_mode)
        0:       t[i] = ($countones(i[5:0]) % 2) == 1;
        1:       t[i] = (i >= 32);
        default: t[i] = golden[i];
      endcase
    end
    return t;
  endfunction

  task automatic test_start_abort_same_cycle();
    start_i = 1'b1;
    abort_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    abort_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || done_o !== 1'b0 || vec_o !== '0) begin
      errors++;
      $display("FAIL start_abort: busy=%b done=%b vec=%0d want 0/0/0", busy_o, done_o, vec_o);
    end
  endtask

  task automatic test_reset_mid_sweep();
    start_and_reach("rstmid", 30);
    test_reset();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
    eval_mode = 0; golden = '0; model_tt = '0;
`ifdef MISMATCH_CHECK_EN
    expect_i = PARITY6_TT; last_mm = 1'b0; last_ff = '0;
`endif
    repeat (2) @(posedge clk);
    test_reset();

    // 1: parity evaluator
    eval_mode = 0;
    run_sweep("parity", 64'h6996966996696996, -1);

    // 2: Y = A
    eval_mode = 1;
    run_sweep("y_eq_a", 64'hFFFFFFFF00000000, -1);

    // 3: abort at vector 10, then start+abort together
    eval_mode = 0;
    test_abort("abort10", 10);
    test_start_abort_same_cycle();

    // 4: start re-pulse mid-sweep is ignored
    eval_mode = 1;
    run_sweep("restart20", 64'hFFFFFFFF00000000, 20);

    // 5: reset at vector 30, then a fresh sweep
    eval_mode = 0;
    test_reset_mid_sweep();
    run_sweep("after_rst", 64'h6996966996696996, -1);

    // Random evaluator tables and random abort points
    eval_mode = 2;
    for (int r = 0; r < 3; r++) begin
      golden = {$urandom(), $urandom()};
      run_sweep("rand_tt", golden, -1);
      golden = {$urandom(), $urandom()};
      test_abort("rand_abort", $urandom_range(1, 62));
    end

`ifdef MISMATCH_CHECK_EN
    // 6: mismatch detection
    eval_mode = 0;
    expect_i  = PARITY6_TT ^ (64'd1 << 37) ^ (64'd1 << 50);
    run_sweep("mm_flip", PARITY6_TT, -1);
    checks++;
    if (last_mm !== 1'b1 || last_ff !== 6'd37) begin
      errors++;
      $display("FAIL mm_flip: mm=%b ff=%0d want 1/37", last_mm, last_ff);
    end
    expect_i = PARITY6_TT;
    run_sweep("mm_clean", PARITY6_TT, -1);
    checks++;
    if (last_mm !== 1'b0) begin
      errors++;
      $display("FAIL mm_clean: mm=%b want 0", last_mm);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
